packet_identifier: RTL and testbench



---
 rtl/packet_identifier.sv | 159 +++++++++++++++
 tb/tb_packet_identifier.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_identifier.sv
// PCIe Gen1/Gen2 receive framing identifier.
// Marks TLP/DLLP bytes in a 64-byte symbol block, one cycle late.
module packet_identifier (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] data_in,
  input  logic         valid_pd,
  input  logic [2:0]   gen,
  input  logic         linkup,
  input  logic [63:0]  DK,
  output logic [511:0] data_out,
  output logic [63:0]  pl_valid,
  output logic [63:0]  pl_dlpstart,
  output logic [63:0]  pl_dlpend,
  output logic [63:0]  pl_tlpstart,
  output logic [63:0]  pl_tlpedb,
  output logic [63:0]  pl_tlpend,
  output logic         w
);

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_TLP  = 2'd1,
    IN_DLLP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t scan_st;

  logic [63:0] v_c;
  logic [63:0] ds_c;
  logic [63:0] de_c;
  logic [63:0] ts_c;
  logic [63:0] te_c;
  logic [63:0] tn_c;

  logic gen_ok;
  logic scan_en;

  assign gen_ok  = (gen == 3'd0) || (gen == 3'd1);
  assign scan_en = linkup && gen_ok && valid_pd;

  // Byte-serial walk; the state after byte i feeds byte i+1.
  always_comb begin
    logic [7:0] b;
    logic       is_stp;
    logic       is_sdp;
    logic       is_end;
    logic       is_edb;
    logic       is_k;
    scan_st = state_q;
    v_c  = '0;
    ds_c = '0;
    de_c = '0;
    ts_c = '0;
    te_c = '0;
    tn_c = '0;
    b      = '0;
    is_k   = 1'b0;
    is_stp = 1'b0;
    is_sdp = 1'b0;
    is_end = 1'b0;
    is_edb = 1'b0;
    for (int i = 0; i < 64; i++) begin
      b      = data_in[8*i +: 8];
      is_k   = DK[i];
      is_stp = is_k && (b == SYM_STP);
      is_sdp = is_k && (b == SYM_SDP);
      is_end = is_k && (b == SYM_END);
      is_edb = is_k && (b == SYM_EDB);
      case (scan_st)
        IDLE: begin
          unique case (1'b1)
            is_stp: begin
              ts_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              scan_st = IN_TLP;
            end
            is_sdp: begin
              ds_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              scan_st = IN_DLLP;
            end
            default: ;
          endcase
        end
        IN_TLP: begin
          unique case (1'b1)
            !is_k: v_c[i] = 1'b1;
            is_end: begin
              tn_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              scan_st = IDLE;
            end
            is_edb: begin
              te_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              scan_st = IDLE;
            end
            default: scan_st = IDLE;
          endcase
        end
        IN_DLLP: begin
          unique case (1'b1)
            !is_k: v_c[i] = 1'b1;
            is_end: begin
              de_c[i] = 1'b1;
              v_c[i]  = 1'b1;
              scan_st = IDLE;
            end
            default: scan_st = IDLE;
          endcase
        end
        default: scan_st = IDLE;
      endcase
    end
  end

  // Link down or unsupported rate drops any open packet; a gap holds it.
  always_comb begin
    state_d = state_q;
    if (!linkup || !gen_ok) begin
      state_d = IDLE;
    end else if (valid_pd) begin
      state_d = scan_st;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_out    <= '0;
      pl_valid    <= '0;
      pl_dlpstart <= '0;
      pl_dlpend   <= '0;
      pl_tlpstart <= '0;
      pl_tlpedb   <= '0;
      pl_tlpend   <= '0;
      w           <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out    <= data_in;
      pl_valid    <= scan_en ? v_c  : '0;
      pl_dlpstart <= scan_en ? ds_c : '0;
      pl_dlpend   <= scan_en ? de_c : '0;
      pl_tlpstart <= scan_en ? ts_c : '0;
      pl_tlpedb   <= scan_en ? te_c : '0;
      pl_tlpend   <= scan_en ? tn_c : '0;
      w           <= scan_en && (scan_st != IDLE);
    end
  end

endmodule

// File: tb/tb_packet_identifier.sv
// Scoreboard bench for packet_identifier.
// Expected blocks are queued at drive time and popped after the edge.
module tb_packet_identifier;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] data_in;
  logic         valid_pd;
  logic [2:0]   gen;
  logic         linkup;
  logic [63:0]  DK;
  logic [511:0] data_out;
  logic [63:0]  pl_valid;
  logic [63:0]  pl_dlpstart;
  logic [63:0]  pl_dlpend;
  logic [63:0]  pl_tlpstart;
  logic [63:0]  pl_tlpedb;
  logic [63:0]  pl_tlpend;
  logic         w;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  v;
    logic [63:0]  ds;
    logic [63:0]  de;
    logic [63:0]  ts;
    logic [63:0]  te;
    logic [63:0]  tn;
    logic         w;
  } out_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  packet_identifier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .valid_pd    (valid_pd),
    .gen         (gen),
    .linkup      (linkup),
    .DK          (DK),
    .data_out    (data_out),
    .pl_valid    (pl_valid),
    .pl_dlpstart (pl_dlpstart),
    .pl_dlpend   (pl_dlpend),
    .pl_tlpstart (pl_tlpstart),
    .pl_tlpedb   (pl_tlpedb),
    .pl_tlpend   (pl_tlpend),
    .w           (w)
  );

  function automatic logic [511:0] fill(input int seed);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      r[8*i +: 8] = 8'((seed + i * 7) & 255);
    return r;
  endfunction

  function automatic logic [511:0] put(
    input logic [511:0] d, input int i, input logic [7:0] b);
    logic [511:0] r;
    r = d;
    r[8*i +: 8] = b;
    return r;
  endfunction

  function automatic out_t mk(
    input logic [511:0] d, input logic [63:0] v,
    input logic [63:0] ds, input logic [63:0] de,
    input logic [63:0] ts, input logic [63:0] te,
    input logic [63:0] tn, input logic wv);
    out_t e;
    e.d = d; e.v = v; e.ds = ds; e.de = de;
    e.ts = ts; e.te = te; e.tn = tn; e.w = wv;
    return e;
  endfunction

  function automatic out_t obs();
    return mk(data_out, pl_valid, pl_dlpstart, pl_dlpend,
              pl_tlpstart, pl_tlpedb, pl_tlpend, w);
  endfunction

  task automatic cyc(input logic [511:0] d, input logic [63:0] k,
                     input logic vp, input logic [2:0] g,
                     input logic lu);
    @(negedge clk);
    data_in  = d;
    DK       = k;
    valid_pd = vp;
    gen      = g;
    linkup   = lu;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, o;
    rst_n = 1'b0;
    exp_q.push_back(mk('0, 0, 0, 0, 0, 0, 0, 1'b0));
    cyc(put(fill(3), 0, 8'hFB), 64'h1, 1'b1, 3'd0, 1'b1);
    o = obs();
    e = exp_q.pop_front();
    n_vec++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset: got v=%h ts=%h w=%b d0=%h want zeros",
               o.v, o.ts, o.w, o.d[63:0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    out_t e, o;
    logic [511:0] d;
    for (int n = 0; n < 2; n++) begin
      d = fill(11 + n);
      exp_q.push_back(mk(d, 0, 0, 0, 0, 0, 0, 1'b0));
      cyc(d, 64'h0, 1'b0, 3'd0, 1'b1);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL idle%0d: got v=%h w=%b d=%h want v=0 d=%h",
                 n, o.v, o.w, o.d[127:0], e.d[127:0]);
      end
    end
  endtask

  function automatic logic [511:0] short_tlp();
    return put(put(fill(40), 0, 8'hFB), 15, 8'hFD);
  endfunction

  task automatic test_short_tlp();
    out_t e, o;
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back(mk(short_tlp(), 64'hFFFF, 0, 0,
                         64'h1, 0, 64'h8000, 1'b0));
      cyc(short_tlp(), 64'h8001, 1'b1, 3'(g), 1'b1);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL short_tlp gen%0d: got v=%h ts=%h tn=%h w=%b want v=%h ts=%h tn=%h w=%b",
                 g, o.v, o.ts, o.tn, o.w, e.v, e.ts, e.tn, e.w);
      end
    end
  endtask

  task automatic test_long_tlp();
    out_t e, o;
    logic [511:0] a, b;
    a = put(fill(50), 0, 8'hFB);
    b = put(put(fill(60), 5, 8'hFD), 20, 8'hFB);
    exp_q.push_back(mk(a, '1, 0, 0, 64'h1, 0, 0, 1'b1));
    exp_q.push_back(mk(b, 64'h3F, 0, 0, 0, 0, 64'h20, 1'b0));
    cyc(a, 64'h1, 1'b1, 3'd0, 1'b1);
    o = obs();
    e = exp_q.pop_front();
    n_vec++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL long_a: got v=%h ts=%h w=%b want v=%h ts=%h w=%b",
               o.v, o.ts, o.w, e.v, e.ts, e.w);
    end
    // byte 20 is FB as data only
    cyc(b, 64'h20, 1'b1, 3'd0, 1'b1);
    o = obs();
    e = exp_q.pop_front();
    n_vec++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL long_b: got v=%h ts=%h tn=%h w=%b want v=%h tn=%h w=%b",
               o.v, o.ts, o.tn, o.w, e.v, e.tn, e.w);
    end
  endtask

  task automatic test_dllp_tlp();
    out_t e, o;
    logic [511:0] d;
    d = fill(70);
    d = put(d, 0, 8'h5C);
    d = put(d, 7, 8'hFD);
    d = put(d, 8, 8'hFB);
    d = put(d, 11, 8'hFE);
    exp_q.push_back(mk(d, 64'hFFF, 64'h1, 64'h80,
                       64'h100, 64'h800, 0, 1'b0));
    cyc(d, 64'h981, 1'b1, 3'd0, 1'b1);
    o = obs();
    e = exp_q.pop_front();
    n_vec++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL dllp_tlp: got v=%h ds=%h de=%h ts=%h te=%h tn=%h want v=%h ds=%h de=%h ts=%h te=%h",
               o.v, o.ds, o.de, o.ts, o.te, o.tn,
               e.v, e.ds, e.de, e.ts, e.te);
    end
  endtask

  task automatic test_abort_gating();
    out_t e, o;
    logic [511:0] d [4];
    logic [63:0]  k [4];
    logic         lu [4];
    d[0] = put(put(fill(80), 0, 8'hFB), 3, 8'hF7);
    k[0] = 64'h9;  lu[0] = 1'b1;
    d[1] = put(fill(81), 0, 8'hFB);
    k[1] = 64'h1;  lu[1] = 1'b1;
    d[2] = fill(82);
    k[2] = 64'h0;  lu[2] = 1'b0;
    d[3] = fill(83);
    k[3] = 64'h0;  lu[3] = 1'b1;
    exp_q.push_back(mk(d[0], 64'h7, 0, 0, 64'h1, 0, 0, 1'b0));
    exp_q.push_back(mk(d[1], '1, 0, 0, 64'h1, 0, 0, 1'b1));
    exp_q.push_back(mk(d[2], 0, 0, 0, 0, 0, 0, 1'b0));
    exp_q.push_back(mk(d[3], 0, 0, 0, 0, 0, 0, 1'b0));
    for (int n = 0; n < 4; n++) begin
      cyc(d[n], k[n], 1'b1, 3'd0, lu[n]);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL abort_gate%0d: got v=%h ts=%h tn=%h te=%h w=%b want v=%h ts=%h w=%b",
                 n, o.v, o.ts, o.tn, o.te, o.w, e.v, e.ts, e.w);
      end
    end
  endtask

  task automatic test_hold();
    out_t e, o;
    logic [511:0] d [3];
    logic [63:0]  k [3];
    logic         vp [3];
    d[0] = put(fill(90), 0, 8'hFB);
    k[0] = 64'h1;  vp[0] = 1'b1;
    d[1] = put(fill(91), 0, 8'hFD);
    k[1] = 64'h1;  vp[1] = 1'b0;
    d[2] = put(fill(92), 2, 8'hFD);
    k[2] = 64'h4;  vp[2] = 1'b1;
    exp_q.push_back(mk(d[0], '1, 0, 0, 64'h1, 0, 0, 1'b1));
    exp_q.push_back(mk(d[1], 0, 0, 0, 0, 0, 0, 1'b0));
    exp_q.push_back(mk(d[2], 64'h7, 0, 0, 0, 0, 64'h4, 1'b0));
    for (int n = 0; n < 3; n++) begin
      cyc(d[n], k[n], vp[n], 3'd1, 1'b1);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL hold%0d: got v=%h tn=%h w=%b want v=%h tn=%h w=%b",
                 n, o.v, o.tn, o.w, e.v, e.tn, e.w);
      end
    end
  endtask

  task automatic test_gen3();
    out_t e, o;
    logic [511:0] d [2];
    logic [63:0]  k [2];
    logic [2:0]   g [2];
    d[0] = short_tlp();
    k[0] = 64'h8001;  g[0] = 3'd3;
    d[1] = put(fill(95), 0, 8'hFB);
    k[1] = 64'h1;     g[1] = 3'd2;
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(mk(d[n], 0, 0, 0, 0, 0, 0, 1'b0));
      cyc(d[n], k[n], 1'b1, g[n], 1'b1);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL gen3_%0d: got v=%h ts=%h w=%b d=%h want zeros d=%h",
                 n, o.v, o.ts, o.w, o.d[63:0], e.d[63:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    logic [511:0] d [4];
    logic [63:0]  k [4];
    d[0] = put(fill(100), 63, 8'hFB);
    k[0] = 64'h8000_0000_0000_0000;
    d[1] = put(put(fill(101), 0, 8'hFD), 1, 8'hFE);
    k[1] = 64'h3;
    d[2] = put(put(fill(102), 0, 8'h5C), 2, 8'hFE);
    k[2] = 64'h5;
    d[3] = put(put(put(fill(103), 0, 8'h5C), 1, 8'hFD), 2, 8'hFB);
    k[3] = 64'h7;
    exp_q.push_back(mk(d[0], 64'h8000_0000_0000_0000, 0, 0,
                       64'h8000_0000_0000_0000, 0, 0, 1'b1));
    exp_q.push_back(mk(d[1], 64'h1, 0, 0, 0, 0, 64'h1, 1'b0));
    exp_q.push_back(mk(d[2], 64'h3, 64'h1, 0, 0, 0, 0, 1'b0));
    exp_q.push_back(mk(d[3], '1, 64'h1, 64'h2, 64'h4, 0, 0, 1'b1));
    for (int n = 0; n < 4; n++) begin
      cyc(d[n], k[n], 1'b1, 3'd0, 1'b1);
      o = obs();
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL b2b%0d: got v=%h ds=%h de=%h ts=%h te=%h tn=%h w=%b want v=%h ds=%h de=%h ts=%h tn=%h w=%b",
                 n, o.v, o.ds, o.de, o.ts, o.te, o.tn, o.w,
                 e.v, e.ds, e.de, e.ts, e.tn, e.w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    data_in  = '0;
    DK       = '0;
    valid_pd = 1'b0;
    gen      = 3'd0;
    linkup   = 1'b0;
    test_reset();
    test_idle();
    test_short_tlp();
    test_long_tlp();
    test_dllp_tlp();
    test_abort_gating();
    test_hold();
    test_gen3();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
